uart_rx_simplex: RTL

//   Serial-to-parallel UART receiver: the receiving end of the simplex UART link.

---
 rtl/uart_rx_simplex_if.sv | 41 ++++
 rtl/uart_rx_simplex.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_simplex_if.sv
// Parallel-side bundle of the UART receiver: serial line in, byte/strobes out.
// Optional UART_RX_PARITY_EN adds the parity_err strobe; dbg_state mirrors the FSM.
interface uart_rx_simplex_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 done;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif
  logic [2:0]           dbg_state;

  // Handshake: no ready/backpressure. done (or frame_err) is a one-cycle
  // valid strobe; the consumer must capture dout in the cycle done is high.
  modport slave (
    input  rx,
    output dout,
    output done,
    output frame_err,
    output busy,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output dbg_state
  );

  modport master (
    output rx,
    input  dout,
    input  done,
    input  frame_err,
    input  busy,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  dbg_state
  );
endinterface

// File: rtl/uart_rx_simplex.sv
// Oversampling UART receiver: start detect, mid-bit sampling, LSB-first byte.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err strobe.
module uart_rx_simplex #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_simplex_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t               state_q;
  logic                 rx_meta_q;
  logic                 rxs_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 done_q;
  logic                 frame_err_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= bus.rx;
      rxs_q       <= rx_meta_q;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rxs_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            par_bad_q <= rxs_q ^ (^shreg_q);
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              dout_q  <= shreg_q;
              done_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // A stuck-low line must go high before a new start can be seen.
          if (rxs_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.done       = done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif
  assign bus.dbg_state  = state_q;
endmodule
